// File: rtl/uart_tx_engine.sv
// UART transmit engine: latches a byte on a load strobe and serialises an
// 11-bit frame (start, data LSB first, optional parity, stop/pad ones) at
// k_lat clocks per bit. txrdy is high when the engine can take another byte.
module uart_tx_engine #(
  parameter int KW         = 19,
  parameter int FRAME_BITS = 11,
  parameter int BC_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [KW-1:0] k,
  input  logic          load,
  input  logic [7:0]    out_port,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  output logic          tx,
  output logic          txrdy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                r_state, w_state_nxt;
  logic [KW-1:0]         r_k_lat, w_k_lat_nxt;
  logic [KW-1:0]         r_btc, w_btc_nxt;
  logic [BC_W-1:0]       r_bc, w_bc_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic                  r_txrdy, w_txrdy_nxt;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_btu;
  logic                  w_par;

  // Parity over the bits actually sent; ohel flips even to odd sense.
  function automatic logic parity_bit(input logic [7:0] d, input logic e,
                                      input logic odd);
    logic [7:0] w_sel;
    w_sel = e ? d : {1'b0, d[6:0]};
    return (^w_sel) ^ odd;
  endfunction

  // Assemble the frame from the live inputs; only consumed on an accepted load,
  // so later input changes cannot disturb a frame already in the shifter.
  always_comb begin
    w_par      = parity_bit(out_port, eight, ohel);
    w_frame    = '1;
    w_frame[0] = 1'b0;
    w_frame[7:1] = out_port[6:0];
    if (eight) begin
      w_frame[8] = out_port[7];
      w_frame[9] = pen ? w_par : 1'b1;
    end else begin
      w_frame[8] = pen ? w_par : 1'b1;
    end
  end

  // Next-state logic: bit-time counting, shifting and frame termination.
  always_comb begin
    w_state_nxt = r_state;
    w_k_lat_nxt = r_k_lat;
    w_btc_nxt   = r_btc;
    w_bc_nxt    = r_bc;
    w_shift_nxt = r_shift;
    w_txrdy_nxt = r_txrdy;
    w_btu       = (r_state == SHIFT) && (r_btc == r_k_lat - KW'(1));
    case (r_state)
      IDLE: begin
        if (load && (k != '0)) begin
          w_state_nxt = SHIFT;
          w_k_lat_nxt = k;
          w_shift_nxt = w_frame;
          w_btc_nxt   = '0;
          w_bc_nxt    = '0;
          w_txrdy_nxt = 1'b0;
        end
      end
      SHIFT: begin
        if (w_btu) begin
          w_btc_nxt   = '0;
          w_shift_nxt = {1'b1, r_shift[FRAME_BITS-1:1]};
          if (r_bc == BC_W'(FRAME_BITS - 1)) begin
            // Last bit time done: shifter has drained to all ones.
            w_state_nxt = IDLE;
            w_bc_nxt    = '0;
            w_txrdy_nxt = 1'b1;
          end else begin
            w_bc_nxt = r_bc + BC_W'(1);
          end
        end else begin
          w_btc_nxt = r_btc + KW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k_lat <= '0;
      r_btc   <= '0;
      r_bc    <= '0;
      r_shift <= '1;
      r_txrdy <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_k_lat <= w_k_lat_nxt;
      r_btc   <= w_btc_nxt;
      r_bc    <= w_bc_nxt;
      r_shift <= w_shift_nxt;
      r_txrdy <= w_txrdy_nxt;
    end
  end

  assign tx    = r_shift[0];
  assign txrdy = r_txrdy;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of frames with hand-computed
// bit patterns plus hand-written reset, k==0 and back-to-back sequences.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] k;
  logic        load;
  logic [7:0]  out_port;
  logic        eight, pen, ohel;
  logic        tx, txrdy;

  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_engine dut (
    .clk(clk), .reset(reset), .k(k), .load(load), .out_port(out_port),
    .eight(eight), .pen(pen), .ohel(ohel), .tx(tx), .txrdy(txrdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          k;
    logic [7:0]  d;
    logic        eight, pen, ohel;
    logic [10:0] exp;        // exp[j] = frame bit j, start bit is bit 0
    int          poke;       // frame cycle at which inputs are disturbed, -1 none
    logic        poke_load;
    int          poke_k;
    logic        poke_eight;
    int          idle;       // cycles of idle line checked after the frame
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Load one frame and check every bit is held for exactly k clocks with
  // txrdy low, then txrdy/tx high on the following cycle.
  task automatic run_frame(input vec_t v);
    int cyc;
    logic ok;
    k        = 19'(v.k);
    out_port = v.d;
    eight    = v.eight;
    pen      = v.pen;
    ohel     = v.ohel;
    load     = 1'b1;
    tick();
    load = 1'b0;
    cyc  = 0;
    for (int j = 0; j < 11; j++) begin
      ok = 1'b1;
      for (int c = 0; c < v.k; c++) begin
        if (tx !== v.exp[j] || txrdy !== 1'b0) ok = 1'b0;
        if (cyc == v.poke) begin
          load     = v.poke_load;
          out_port = 8'hFF;
          k        = 19'(v.poke_k);
          eight    = v.poke_eight;
        end else begin
          load = 1'b0;
        end
        cyc++;
        tick();
      end
      chk($sformatf("%s bit%0d", v.name, j), {31'd0, ok}, 32'd1);
    end
    load = 1'b0;
    chk($sformatf("%s end txrdy", v.name), {31'd0, txrdy}, 32'd1);
    chk($sformatf("%s end tx", v.name), {31'd0, tx}, 32'd1);
    if (v.idle > 0) begin
      ok = 1'b1;
      for (int c = 0; c < v.idle; c++) begin
        tick();
        if (tx !== 1'b1 || txrdy !== 1'b1) ok = 1'b0;
      end
      chk($sformatf("%s stays idle", v.name), {31'd0, ok}, 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{"8N 55",   109, 8'h55, 1'b1, 1'b0, 1'b0, 11'b11010101010, -1, 1'b0, 0, 1'b0, 0};
    vecs[1] = '{"7E C1",   4,   8'hC1, 1'b0, 1'b1, 1'b0, 11'b11010000010, -1, 1'b0, 0, 1'b0, 0};
    vecs[2] = '{"7O C1",   4,   8'hC1, 1'b0, 1'b1, 1'b1, 11'b11110000010, -1, 1'b0, 0, 1'b0, 0};
    vecs[3] = '{"busy A5", 8,   8'hA5, 1'b1, 1'b0, 1'b0, 11'b11101001010, 30, 1'b1, 8, 1'b1, 20};
    vecs[4] = '{"midchg",  10,  8'h3C, 1'b1, 1'b0, 1'b0, 11'b11001111000, 40, 1'b0, 3, 1'b0, 0};
    vecs[5] = '{"8E 07",   2,   8'h07, 1'b1, 1'b1, 1'b0, 11'b11000001110, -1, 1'b0, 0, 1'b0, 0};
    vecs[6] = '{"8O FF",   3,   8'hFF, 1'b1, 1'b1, 1'b1, 11'b11111111110, -1, 1'b0, 0, 1'b0, 0};
    vecs[7] = '{"7N 80",   1,   8'h80, 1'b0, 1'b0, 1'b0, 11'b11100000000, -1, 1'b0, 0, 1'b0, 0};

    // Reset with a simultaneous load: reset wins and nothing starts.
    reset = 1'b1; load = 1'b1; k = 19'd5; out_port = 8'h00;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    tick(); tick();
    reset = 1'b0; load = 1'b0;
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset txrdy", {31'd0, txrdy}, 32'd1);
    tick(); tick();
    chk("post-reset idle", {30'd0, tx, txrdy}, 32'd3);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // k == 0: load must be ignored.
    k = 19'd0; out_port = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    chk("k0 tx", {31'd0, tx}, 32'd1);
    chk("k0 txrdy", {31'd0, txrdy}, 32'd1);
    tick(); tick();
    chk("k0 still idle", {30'd0, tx, txrdy}, 32'd3);

    // Reset mid-frame, then a clean new frame.
    k = 19'd20; out_port = 8'h00; eight = 1'b1; pen = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("pre-reset start bit", {30'd0, tx, txrdy}, 32'd0);
    for (int c = 0; c < 50; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset tx", {31'd0, tx}, 32'd1);
    chk("midreset txrdy", {31'd0, txrdy}, 32'd1);
    run_frame('{"after reset", 20, 8'h5A, 1'b1, 1'b0, 1'b0, 11'b11010110100, -1, 1'b0, 0, 1'b0, 0});

    // Back-to-back at k=1: second load on the cycle txrdy returns high.
    run_frame('{"b2b 00", 1, 8'h00, 1'b1, 1'b0, 1'b0, 11'b11000000000, -1, 1'b0, 0, 1'b0, 0});
    run_frame('{"b2b FF", 1, 8'hFF, 1'b1, 1'b0, 1'b0, 11'b11111111110, -1, 1'b0, 0, 1'b0, 3});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Transmit half of the UART; sits directly downstream of the baud decoder and consumes its 19-bit bit-time count k.
- Accepts a byte from the processor's output port on a one-cycle load strobe.
- Serialises a fixed 11-bit frame (start, data LSB first, optional parity, stop/pad ones) on tx and raises txrdy when it can accept the next byte.
- Contains the bit-time counter, bit counter, shift register and frame-format logic.

Parameters:
- KW, 19, width of the bit-time count input k.
- FRAME_BITS, 11, bit times per frame including start bit.
- BC_W, 4, width of the bit counter; must hold FRAME_BITS.

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- k  input  KW  clocks per bit time, from baud decoder.
- load  input  1  one-cycle strobe: latch out_port and start a frame.
- out_port  input  8  byte to transmit.
- eight  input  1  1 = 8 data bits, 0 = 7 data bits (out_port[7] ignored).
- pen  input  1  parity enable.
- ohel  input  1  parity sense: 0 = even, 1 = odd.
- tx  output  1  serial line, idles high.
- txrdy  output  1  high when idle and able to accept load.

Behaviour:
- Reset values: tx=1, txrdy=1, bit-time counter=0, bit counter=0, shift register all ones, state IDLE. Reset in mid-frame aborts the frame; tx=1 on the cycle after reset is sampled.
- States:
  - IDLE: tx=1, txrdy=1.
  - SHIFT: frame in progress, txrdy=0.
- Load acceptance:
  - load is accepted only in IDLE with k!=0.
  - load while busy, or with k==0, is ignored; no state change and no queuing.
- Effects of an accepted load on cycle n:
  - k, eight, pen and ohel are latched (k_lat). Changes to these inputs mid-frame have no effect on the frame in progress.
  - The 11-bit frame is built into the shift register.
  - At cycle n+1: tx=0 (start bit) and txrdy=0.
- Frame contents, bit 0 (start) first:
  - eight=1, pen=1: 0, d0..d7, P, 1.
  - eight=1, pen=0: 0, d0..d7, 1, 1.
  - eight=0, pen=1: 0, d0..d6, P, 1, 1.
  - eight=0, pen=0: 0, d0..d6, 1, 1, 1.
- Parity: P = XOR of the transmitted data bits (d[7:0] if eight, else d[6:0]), inverted when ohel=1.
- Bit timing:
  - The bit-time counter runs from 0 to k_lat-1. On the cycle it equals k_lat-1 it emits an internal btu pulse, wraps to 0, shifts the register right (filling with 1), and increments the bit counter.
  - Each frame bit is held on tx for exactly k_lat clocks.
- End of frame:
  - When the bit counter reaches FRAME_BITS on a btu, the engine returns to IDLE.
  - At cycle n+1+11*k_lat: tx=1 and txrdy=1.
  - A load on that same cycle is accepted, giving back-to-back frames with no idle gap.
- Registering: tx is driven from the shift register LSB, and txrdy from a flop; there are no combinational paths from inputs to outputs.
- Simultaneous reset and load: reset wins.
- k_lat=1 is legal: one clock per bit, 11-clock frame.

Test Plan:
- Basic 8N frame: reset; k=109, eight=1, pen=0, out_port=8'h55, load for 1 cycle. Required:
  - tx shows 0,1,0,1,0,1,0,1,0,1,1, each bit exactly 109 clocks.
  - txrdy low for exactly 1199 clocks, then high.
- Parity, 7-bit: k=4, eight=0, pen=1, out_port=8'hC1 (d[6:0] has 2 ones).
  - ohel=0: parity bit 0, frame 0,1,0,0,0,0,0,1,0,1,1.
  - ohel=1: parity bit 1.
  - Bit 7 of out_port must not appear on tx.
- Busy load ignored: during a k=8 frame of 8'hA5, pulse load with 8'hFF mid-frame. Required:
  - The frame carries A5 unchanged.
  - txrdy rises at 88 clocks after start.
  - No second frame follows.
- Mid-frame input changes: start a frame with k=10, then change k to 3 and eight to 0 at bit 4. All bits must stay 10 clocks and the 8-bit format must be kept.
- k=0 and reset: with k=0, load leaves tx=1 and txrdy=1. Assert reset mid-frame (k=20); the next cycle must show tx=1 and txrdy=1, and a new load must produce a clean start bit.
- Back-to-back: k=1, load 8'h00 and then load 8'hFF on the cycle txrdy returns high. The second start bit must follow the first frame's last stop bit with no idle gap.
